uart_tx_fifo: RTL



---
 rtl/uart_pkg.sv | 39 +++
 rtl/uart_tx_fifo_fifo.sv | 54 +++++
 rtl/uart_tx_fifo.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the buffered UART transmitter.
// Parity/FSM enums and 50 MHz baud divisors.
package uart_pkg;

  typedef enum logic [1:0] {
    PAR_NONE = 2'd0,
    PAR_EVEN = 2'd1,
    PAR_ODD  = 2'd2
  } parity_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  localparam int unsigned DIV_300    = 166667;
  localparam int unsigned DIV_9600   = 5208;
  localparam int unsigned DIV_38400  = 1302;
  localparam int unsigned DIV_115200 = 434;
  localparam int unsigned DIV_MIN    = 2;

  // Mode 3 is an alias for "no parity".
  function automatic parity_t decode_parity(
    input logic [1:0] mode
  );
    parity_t p;
    p = PAR_NONE;
    unique case (mode)
      2'd1:    p = PAR_EVEN;
      2'd2:    p = PAR_ODD;
      default: p = PAR_NONE;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/uart_tx_fifo_fifo.sv
// Generic single-clock first-word-fall-through FIFO.
// Ports: wr_en/wr_data, rd_en/rd_data, full, empty, level.
module uart_sync_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             wr_ok, rd_ok;

  // Extra pointer bit distinguishes full from empty.
  assign level   = wr_ptr_q - rd_ptr_q;
  assign full    = (level == (AW+1)'(DEPTH));
  assign empty   = (level == '0);
  assign wr_ok   = wr_en && !full;
  assign rd_ok   = rd_en && !empty;
  assign rd_data = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (wr_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (rd_ok) rd_ptr_d = rd_ptr_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok) mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: FIFO + frame serialiser.
// Ports: config (baud_div,data_bits,parity_mode,stop2), din handshake, level, busy, TX.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int DIV_W      = 18
) (
  input  logic                          CLK_50M,
  input  logic                          rst_n,
  input  logic [DIV_W-1:0]              baud_div,
  input  logic [3:0]                    data_bits,
  input  logic [1:0]                    parity_mode,
  input  logic                          stop2,
  input  logic [DATA_W-1:0]             din,
  input  logic                          din_valid,
  output logic                          din_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          busy,
  output logic                          TX
);

  state_t              state_q, state_d;
  logic [DIV_W-1:0]    cnt_q, cnt_d;
  logic [DIV_W-1:0]    div_q, div_d;
  logic [3:0]          idx_q, idx_d;
  logic [3:0]          nbits_q, nbits_d;
  parity_t             par_q, par_d;
  logic                stop2_q, stop2_d;
  logic [DATA_W-1:0]   sh_q, sh_d;
  logic                acc_q, acc_d;
  logic                tx_q, tx_d;

  logic                fifo_full, fifo_empty;
  logic [DATA_W-1:0]   fifo_dout;
  logic                pop, bit_end;

  uart_sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_W)
  ) u_fifo (
    .clk     (CLK_50M),
    .rst_n   (rst_n),
    .wr_en   (din_valid),
    .wr_data (din),
    .rd_en   (pop),
    .rd_data (fifo_dout),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (fifo_level)
  );

  assign pop       = (state_q == S_IDLE) && !fifo_empty;
  assign bit_end   = (cnt_q == div_q - 1'b1);
  assign din_ready = !fifo_full;
  assign busy      = (state_q != S_IDLE) || !fifo_empty;
  assign TX        = tx_q;

  // tx_d is the line level of the current state, so TX
  // trails the FSM by exactly one clock.
  always_comb begin
    state_d = state_q;
    cnt_d   = bit_end ? '0 : cnt_q + 1'b1;
    div_d   = div_q;
    idx_d   = idx_q;
    nbits_d = nbits_q;
    par_d   = par_q;
    stop2_d = stop2_q;
    sh_d    = sh_q;
    acc_d   = acc_q;
    tx_d    = 1'b1;
    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (pop) begin
          state_d = S_START;
          div_d   = (baud_div < DIV_W'(DIV_MIN))
                    ? DIV_W'(DIV_MIN) : baud_div;
          nbits_d = (data_bits >= 4'd5 &&
                     data_bits <= 4'(DATA_W))
                    ? data_bits : 4'(DATA_W);
          par_d   = decode_parity(parity_mode);
          stop2_d = stop2;
          sh_d    = fifo_dout;
          acc_d   = 1'b0;
          idx_d   = '0;
        end
      end
      S_START: begin
        tx_d = 1'b0;
        if (bit_end) state_d = S_DATA;
      end
      S_DATA: begin
        tx_d = sh_q[0];
        if (bit_end) begin
          sh_d  = sh_q >> 1;
          acc_d = acc_q ^ sh_q[0];
          idx_d = idx_q + 1'b1;
          if (idx_q == nbits_q - 4'd1) begin
            idx_d   = '0;
            state_d = (par_q == PAR_NONE) ? S_STOP : S_PARITY;
          end
        end
      end
      S_PARITY: begin
        tx_d = acc_q ^ (par_q == PAR_ODD);
        if (bit_end) state_d = S_STOP;
      end
      S_STOP: begin
        tx_d = 1'b1;
        if (bit_end) begin
          if (stop2_q && idx_q == '0) begin
            idx_d = 4'd1;
          end else begin
            idx_d   = '0;
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK_50M or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      div_q   <= DIV_W'(DIV_MIN);
      idx_q   <= '0;
      nbits_q <= 4'(DATA_W);
      par_q   <= PAR_NONE;
      stop2_q <= 1'b0;
      sh_q    <= '0;
      acc_q   <= 1'b0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      idx_q   <= idx_d;
      nbits_q <= nbits_d;
      par_q   <= par_d;
      stop2_q <= stop2_d;
      sh_q    <= sh_d;
      acc_q   <= acc_d;
      tx_q    <= tx_d;
    end
  end

endmodule
